// File: rtl/ncl_pkg.sv
// Shared definitions for the NCL 1-of-3 grant sink: handshake state encoding,
// rail indices and small rail-decoding helpers.
package ncl_pkg;

    typedef enum logic {
        WAIT_DATA = 1'b0,
        WAIT_NULL = 1'b1
    } sink_state_t;

    localparam int RAIL0 = 0;
    localparam int RAIL1 = 1;
    localparam int RAIL2 = 2;
    localparam int ID_W  = 2;

    function automatic logic is_onehot3(input logic [2:0] rails);
        return (rails == 3'b001) || (rails == 3'b010) || (rails == 3'b100);
    endfunction

    function automatic logic is_multi3(input logic [2:0] rails);
        return (rails[0] & rails[1]) | (rails[0] & rails[2]) | (rails[1] & rails[2]);
    endfunction

    function automatic logic [ID_W-1:0] rail_to_id(input logic [2:0] rails);
        logic [ID_W-1:0] id;
        case (rails)
            3'b001:  id = ID_W'(RAIL0);
            3'b010:  id = ID_W'(RAIL1);
            3'b100:  id = ID_W'(RAIL2);
            default: id = ID_W'(RAIL0);
        endcase
        return id;
    endfunction

endpackage

// File: rtl/grant_fifo.sv
// Small synchronous FIFO with a registered head entry; the head holds its last
// value once the FIFO drains, and push+pop is accepted even when full.
module grant_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    rd_next_s;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt_s;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] head_nxt_s;
    logic             valid_r;
    logic             empty_s;
    logic             full_s;
    logic             push_eff_s;
    logic             pop_eff_s;

    // Occupancy, qualified push/pop and next head value.
    always_comb begin
        empty_s     = (count_r == {(AW+1){1'b0}});
        full_s      = (count_r == CNT_FULL);
        pop_eff_s   = pop & ~empty_s;
        push_eff_s  = push & (~full_s | pop_eff_s);
        rd_next_s   = rd_ptr_r + AW'(1);
        count_nxt_s = count_r;
        case ({push_eff_s, pop_eff_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
        head_nxt_s = head_r;
        // Next head comes from storage if more remain, otherwise from the incoming push.
        if (pop_eff_s && (count_r > CNT_ONE)) begin
            head_nxt_s = mem_r[rd_next_s];
        end else if (push_eff_s && (empty_s || (pop_eff_s && (count_r == CNT_ONE)))) begin
            head_nxt_s = din;
        end else begin
            head_nxt_s = head_r;
        end
    end

    // Storage, pointers, count and registered head/valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            head_r   <= {WIDTH{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            if (push_eff_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_eff_s) begin
                rd_ptr_r <= rd_next_s;
            end
            count_r <= count_nxt_s;
            head_r  <= head_nxt_s;
            valid_r <= (count_nxt_s != {(AW+1){1'b0}});
        end
    end

    assign dout  = head_r;
    assign valid = valid_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/trinary_grant_sink.sv
// Clocked sink for the 1-of-3 NCL grant channel: synchronises the rails, closes the
// four-phase handshake on trinary_comp, queues grant IDs and counts grants per requester.
module trinary_grant_sink
    import ncl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       trinary,
    output logic             trinary_comp,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  gnt_id,
    input  logic             gnt_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic             err_multi
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [2:0]       sync_r [SYNC_STAGES];
    logic [2:0]       trs_s;
    sink_state_t      state_r;
    logic             comp_r;
    logic             err_r;
    logic             push_r;
    logic [ID_W-1:0]  push_id_r;
    logic [ID_W-1:0]  acc_id_s;
    logic [CNT_W-1:0] cnt0_r;
    logic [CNT_W-1:0] cnt1_r;
    logic [CNT_W-1:0] cnt2_r;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             pop_s;
    logic             accept_s;

    // Rail synchroniser chain; only its last stage is visible to the handshake logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= 3'b000;
            end
        end else begin
            sync_r[0] <= trinary;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Accept a clean DATA wavefront only when the FIFO has (or is freeing) a slot.
    always_comb begin
        trs_s    = sync_r[SYNC_STAGES-1];
        pop_s    = gnt_ready & ~fifo_empty_s;
        acc_id_s = rail_to_id(trs_s);
        if ((state_r == WAIT_DATA) && is_onehot3(trs_s) && (!fifo_full_s || pop_s)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Handshake FSM; the push is registered so the ID lands in the FIFO one edge after comp rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= WAIT_DATA;
            comp_r    <= 1'b0;
            err_r     <= 1'b0;
            push_r    <= 1'b0;
            push_id_r <= {ID_W{1'b0}};
        end else begin
            push_r <= 1'b0;
            if (is_multi3(trs_s)) begin
                err_r <= 1'b1;
            end
            case (state_r)
                WAIT_DATA: begin
                    if (accept_s) begin
                        state_r   <= WAIT_NULL;
                        comp_r    <= 1'b1;
                        push_r    <= 1'b1;
                        push_id_r <= acc_id_s;
                    end
                end
                WAIT_NULL: begin
                    if (trs_s == 3'b000) begin
                        state_r <= WAIT_DATA;
                        comp_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= WAIT_DATA;
                    comp_r  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating per-requester grant counters, bumped on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_r <= {CNT_W{1'b0}};
            cnt1_r <= {CNT_W{1'b0}};
            cnt2_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            case (acc_id_s)
                2'd0:    if (cnt0_r != CNT_MAX) cnt0_r <= cnt0_r + CNT_W'(1);
                2'd1:    if (cnt1_r != CNT_MAX) cnt1_r <= cnt1_r + CNT_W'(1);
                2'd2:    if (cnt2_r != CNT_MAX) cnt2_r <= cnt2_r + CNT_W'(1);
                default: cnt0_r <= cnt0_r;
            endcase
        end
    end

    grant_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ID_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_r),
        .din   (push_id_r),
        .pop   (pop_s),
        .dout  (gnt_id),
        .valid (gnt_valid),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign trinary_comp = comp_r;
    assign err_multi    = err_r;
    assign cnt0         = cnt0_r;
    assign cnt1         = cnt1_r;
    assign cnt2         = cnt2_r;

endmodule

// File: tb/tb_trinary_grant_sink.sv
// Scoreboard bench for trinary_grant_sink: drives the arbiter side of the handshake,
// queues expected IDs at issue time and checks pops in an independent monitor.
module tb_trinary_grant_sink;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  trinary;
    logic        trinary_comp;
    logic        gnt_valid;
    logic [1:0]  gnt_id;
    logic        gnt_ready;
    logic [15:0] cnt0, cnt1, cnt2;
    logic        err_multi;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          exp_q[$];
    int          model_cnt[3];
    int          rdy_mode = 0;

    trinary_grant_sink #(.SYNC_STAGES(2), .FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trinary      (trinary),
        .trinary_comp (trinary_comp),
        .gnt_valid    (gnt_valid),
        .gnt_id       (gnt_id),
        .gnt_ready    (gnt_ready),
        .cnt0         (cnt0),
        .cnt1         (cnt1),
        .cnt2         (cnt2),
        .err_multi    (err_multi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Monitor: every accepted pop must match the oldest expected grant.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && gnt_valid === 1'b1 && gnt_ready === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
            else chk("gnt_id_order", gnt_id, exp_q.pop_front());
        end
    end

    // Random consumer backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 1) gnt_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_comp(input logic v, input int limit, input string name);
        int n = 0;
        while (trinary_comp !== v && n < limit) begin tick(1); n++; end
        chk(name, trinary_comp, v);
    endtask

    task automatic issue(input int rail);
        trinary = 3'b001 << rail;
        exp_q.push_back(rail);
        model_cnt[rail]++;
    endtask

    task automatic grant(input int rail);
        issue(rail);
        wait_comp(1'b1, 300, "comp_rise");
        trinary = 3'b000;
        wait_comp(1'b0, 50, "comp_fall");
    endtask

    task automatic drain();
        gnt_ready = 1'b1;
        tick(10);
        gnt_ready = 1'b0;
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_valid_low", gnt_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) model_cnt[i] = 0;
        // T1: reset held with DATA on the rails
        rst_n = 1'b0; trinary = 3'b010; gnt_ready = 1'b0;
        tick(4);
        chk("rst_comp", trinary_comp, 0);
        chk("rst_valid", gnt_valid, 0);
        chk("rst_id", gnt_id, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        chk("rst_cnt2", cnt2, 0);
        chk("rst_err", err_multi, 0);
        trinary = 3'b000;
        tick(2);
        rst_n = 1'b1;
        tick(3);

        // T2: exact latency of one grant
        issue(0);
        tick(2);
        chk("t2_comp_early", trinary_comp, 0);
        tick(1);
        chk("t2_comp_rise", trinary_comp, 1);
        chk("t2_valid_not_yet", gnt_valid, 0);
        tick(1);
        chk("t2_valid", gnt_valid, 1);
        chk("t2_id", gnt_id, 0);
        chk("t2_cnt0", cnt0, 1);
        trinary = 3'b000;
        tick(2);
        chk("t2_comp_hold", trinary_comp, 1);
        tick(1);
        chk("t2_comp_fall", trinary_comp, 0);
        drain();

        // T3: full FIFO stalls the fifth grant until a pop frees a slot
        grant(0); grant(1); grant(2); grant(0);
        issue(1);
        tick(10);
        chk("t3_stalled_comp", trinary_comp, 0);
        chk("t3_stalled_cnt1", cnt1, model_cnt[1] - 1);
        gnt_ready = 1'b1;
        tick(1);
        gnt_ready = 1'b0;
        chk("t3_accept_on_pop", trinary_comp, 1);
        chk("t3_cnt1", cnt1, model_cnt[1]);
        trinary = 3'b000;
        wait_comp(1'b0, 50, "t3_comp_fall");
        chk("t3_queue_depth", exp_q.size(), 4);
        drain();

        // T4: multi-hot rails flag an error and are not accepted
        trinary = 3'b011;
        tick(6);
        chk("t4_err", err_multi, 1);
        chk("t4_comp", trinary_comp, 0);
        chk("t4_no_push", gnt_valid, 0);
        trinary = 3'b000;
        tick(4);
        chk("t4_err_sticky", err_multi, 1);

        // T5: long-held DATA pushes exactly once
        issue(2);
        tick(20);
        chk("t5_comp", trinary_comp, 1);
        trinary = 3'b000;
        wait_comp(1'b0, 50, "t5_comp_fall");
        chk("t5_cnt2", cnt2, model_cnt[2]);
        drain();

        // Randomised grants under random backpressure
        rdy_mode = 1;
        for (int k = 0; k < 40; k++) begin
            grant(int'($urandom_range(0, 2)));
            tick(int'($urandom_range(0, 3)));
        end
        rdy_mode = 0;
        tick(1);
        drain();
        chk("rand_cnt0", cnt0, model_cnt[0]);
        chk("rand_cnt1", cnt1, model_cnt[1]);
        chk("rand_cnt2", cnt2, model_cnt[2]);

        // T6: reset in the middle of a handshake with two grants queued
        grant(0);
        issue(1);
        wait_comp(1'b1, 50, "t6_comp_rise");
        tick(1);
        chk("t6_two_queued", gnt_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_comp_cleared", trinary_comp, 0);
        chk("t6_fifo_cleared", gnt_valid, 0);
        chk("t6_cnt1_cleared", cnt1, 0);
        exp_q.delete();
        for (int i = 0; i < 3; i++) model_cnt[i] = 0;
        trinary = 3'b000;
        tick(2);
        chk("t6_err_cleared", err_multi, 0);
        rst_n = 1'b1;
        tick(2);
        grant(2);
        drain();
        chk("t6_recover_cnt2", cnt2, model_cnt[2]);
        chk("t6_recover_cnt0", cnt0, model_cnt[0]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
